// File: rtl/route_scheduler.sv
// Purpose : grants one of four sources a timed route to a destination, with round-robin
//           or (ROUTE_PRIORITY_EN defined) fixed-priority arbitration, source 0 highest.
// Ports   : clk, rst_n (async, active low); req[3:0], dest[7:0] (2 bits per source),
//           data_in[15:0] (nibble per source); grant, mux_sel, demux_sel, route_en,
//           data_out, busy are all registered.
// Latency : request in IDLE -> grant after 1 edge -> route_en after 2 edges; route_en
//           stays high for HOLD_CYCLES cycles unless the winner drops req first.
module route_scheduler #(
  parameter int HOLD_CYCLES = 4  // 1..255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [7:0]  dest,
  input  logic [15:0] data_in,
  output logic [3:0]  grant,
  output logic [1:0]  mux_sel,
  output logic [1:0]  demux_sel,
  output logic        route_en,
  output logic [3:0]  data_out,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD, S_RELEASE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  mux_q, mux_d;
  logic [1:0]  demux_q, demux_d;
  logic        route_en_q, route_en_d;
  logic [3:0]  dout_q, dout_d;
  logic        busy_q, busy_d;
  logic [7:0]  cnt_q, cnt_d;
`ifndef ROUTE_PRIORITY_EN
  logic [1:0]  rr_q, rr_d;
`endif

  logic [1:0]  win;
  logic        win_vld;
  logic [3:0]  sel_nibble;

  assign sel_nibble = data_in[{mux_q, 2'b00} +: 4];

  // Arbiter. The loop runs from the lowest-priority candidate to the highest so the
  // last match (highest priority) is the one that sticks.
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
`ifdef ROUTE_PRIORITY_EN
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) begin
        win     = 2'(i);
        win_vld = 1'b1;
      end
    end
`else
    for (int i = 3; i >= 0; i--) begin
      // 2-bit addition wraps modulo 4 by construction.
      if (req[rr_q + 2'(i)]) begin
        win     = rr_q + 2'(i);
        win_vld = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    mux_d      = mux_q;
    demux_d    = demux_q;
    dout_d     = dout_q;
    cnt_d      = cnt_q;
    route_en_d = 1'b0;
`ifndef ROUTE_PRIORITY_EN
    rr_d       = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_GRANT;
          grant_d = 4'b0001 << win;
          mux_d   = win;
          demux_d = dest[{win, 1'b0} +: 2];
        end
      end
      S_GRANT: begin
        if (req[mux_q]) begin
          state_d    = S_HOLD;
          cnt_d      = 8'd0;
          route_en_d = 1'b1;
          dout_d     = sel_nibble;
        end else begin
          state_d = S_RELEASE;
          grant_d = 4'b0000;
`ifndef ROUTE_PRIORITY_EN
          rr_d    = mux_q + 2'd1;
`endif
        end
      end
      S_HOLD: begin
        // The cycle that just ended was routed; leave if it was the last allowed one
        // or if the winner withdrew its request during it.
        if (!req[mux_q] || cnt_q == LAST_CNT) begin
          state_d = S_RELEASE;
          grant_d = 4'b0000;
`ifndef ROUTE_PRIORITY_EN
          rr_d    = mux_q + 2'd1;
`endif
        end else begin
          cnt_d      = cnt_q + 8'd1;
          route_en_d = 1'b1;
          dout_d     = sel_nibble;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= 4'd0;
      mux_q      <= 2'd0;
      demux_q    <= 2'd0;
      route_en_q <= 1'b0;
      dout_q     <= 4'd0;
      busy_q     <= 1'b0;
      cnt_q      <= 8'd0;
`ifndef ROUTE_PRIORITY_EN
      rr_q       <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      mux_q      <= mux_d;
      demux_q    <= demux_d;
      route_en_q <= route_en_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
`ifndef ROUTE_PRIORITY_EN
      rr_q       <= rr_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign mux_sel   = mux_q;
  assign demux_sel = demux_q;
  assign route_en  = route_en_q;
  assign data_out  = dout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_route_scheduler.sv
// Bench for route_scheduler: two instances (HOLD_CYCLES 4 and 1) share one stimulus
// stream; a route-level reference model predicts every registered output each cycle,
// with extra directed checks on grant order, route length, demux stability and reset.
module tb_route_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  dest;
  logic [15:0] data_in;

  logic [3:0] g0, g1, do0, do1;
  logic [1:0] ms0, ms1, ds0, ds1;
  logic       re0, re1, b0, b1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  route_scheduler #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .dest(dest), .data_in(data_in),
    .grant(g0), .mux_sel(ms0), .demux_sel(ds0), .route_en(re0), .data_out(do0), .busy(b0));

  route_scheduler #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .dest(dest), .data_in(data_in),
    .grant(g1), .mux_sel(ms1), .demux_sel(ds1), .route_en(re1), .data_out(do1), .busy(b1));

  // Reference model: where each instance is in its current route.
  // phase 0 = waiting, 1 = granted (setup), 2 = routing, 3 = releasing.
  typedef struct {
    int         phase;
    int         win;
    int         dsel;
    int         rr;
    int         routed;   // route_en cycles delivered so far in this route
    logic [3:0] dout;
  } mdl_t;

  mdl_t m [2];

  function automatic int hold_of(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int pick(int base, logic [3:0] r);
    for (int o = 0; o < 4; o++) begin
      int s;
      s = (base + o) % 4;
      if (r[s]) return s;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) m[k] = '{0, 0, 0, 0, 0, 4'h0};
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int base;
      int s;
`ifdef ROUTE_PRIORITY_EN
      base = 0;
`else
      base = m[k].rr;
`endif
      case (m[k].phase)
        0: begin
          s = pick(base, req);
          if (s >= 0) begin
            m[k].win   = s;
            m[k].dsel  = int'(dest[2*s +: 2]);
            m[k].phase = 1;
          end
        end
        1: begin
          if (req[m[k].win]) begin
            m[k].phase  = 2;
            m[k].routed = 1;
            m[k].dout   = data_in[4*m[k].win +: 4];
          end else begin
            m[k].phase = 3;
            m[k].rr    = (m[k].win + 1) % 4;
          end
        end
        2: begin
          if (!req[m[k].win] || m[k].routed >= hold_of(k)) begin
            m[k].phase = 3;
            m[k].rr    = (m[k].win + 1) % 4;
          end else begin
            m[k].routed = m[k].routed + 1;
            m[k].dout   = data_in[4*m[k].win +: 4];
          end
        end
        default: m[k].phase = 0;
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_inst(input int k, input logic [3:0] g, input logic [1:0] ms,
                              input logic [1:0] ds, input logic re, input logic [3:0] dd,
                              input logic b);
    logic [3:0] eg;
    eg = (m[k].phase == 1 || m[k].phase == 2) ? 4'(1 << m[k].win) : 4'd0;
    check($sformatf("grant_h%0d", hold_of(k)), 8'(g), 8'(eg));
    check($sformatf("mux_sel_h%0d", hold_of(k)), 8'(ms), 8'(m[k].win));
    check($sformatf("demux_sel_h%0d", hold_of(k)), 8'(ds), 8'(m[k].dsel));
    check($sformatf("route_en_h%0d", hold_of(k)), 8'(re), 8'(m[k].phase == 2));
    check($sformatf("data_out_h%0d", hold_of(k)), 8'(dd), 8'(m[k].dout));
    check($sformatf("busy_h%0d", hold_of(k)), 8'(b), 8'(m[k].phase != 0));
  endtask

  task automatic compare_all();
    compare_inst(0, g0, ms0, ds0, re0, do0, b0);
    compare_inst(1, g1, ms1, ds1, re1, do1, b1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int first_on, on_cnt, ngr;
    logic [3:0] prev_g;
    logic [3:0] exp_seq [5];
    logic [3:0] got_seq [5];

    rst_n = 1'b0; req = 4'd0; dest = 8'd0; data_in = 16'd0;
    model_reset();
    #2 compare_all();
    #1 rst_n = 1'b1;

    // Single source 0 to destination 2.
    req = 4'b0001; dest = 8'b0000_0010; data_in = 16'hABC5;
    cycle();
    check("grant_first", 8'(g0), 8'h01);
    check("demux_first", 8'(ds0), 8'h02);
    first_on = -1; on_cnt = 0;
    if (re0) begin first_on = 1; on_cnt++; end
    for (int i = 2; i <= 7; i++) begin
      cycle();
      if (re0) begin
        if (first_on < 0) first_on = i;
        on_cnt++;
      end
      if (re0) check("data_out_src0", 8'(do0), 8'h05);
    end
    check("route_en_start", 8'(first_on), 8'd2);
    check("route_en_len", 8'(on_cnt), 8'd4);
    req = 4'd0;
    repeat (3) cycle();

    // All sources requesting continuously.
    pulse_reset();
`ifdef ROUTE_PRIORITY_EN
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    req = 4'b1111; dest = 8'hE4; ngr = 0; prev_g = 4'd0;
    for (int i = 0; i < 40 && ngr < 5; i++) begin
      data_in = 16'($urandom);
      cycle();
      if (prev_g == 4'd0 && g0 != 4'd0) begin
        got_seq[ngr] = g0;
        ngr++;
      end
      prev_g = g0;
    end
    check("grant_count", 8'(ngr), 8'd5);
    for (int i = 0; i < ngr; i++) check($sformatf("grant_seq%0d", i), 8'(got_seq[i]), 8'(exp_seq[i]));
    req = 4'd0;
    repeat (8) cycle();

    // Source 2 withdraws after its second routed cycle.
    pulse_reset();
    req = 4'b0100; dest = 8'b0011_0000;
    cycle();                // grant
    cycle();                // route_en cycle 1
    cycle();                // route_en cycle 2
    check("drop_on2", 8'(re0), 8'd1);
    req = 4'd0;
    cycle();
    check("drop_route_en", 8'(re0), 8'd0);
    check("drop_grant", 8'(g0), 8'd0);
    cycle();
    req = 4'b1111;
    cycle();
`ifdef ROUTE_PRIORITY_EN
    check("after_drop_grant", 8'(g0), 8'h01);
`else
    check("after_drop_grant", 8'(g0), 8'h08);
`endif
    req = 4'd0;
    repeat (8) cycle();

    // Destination of source 1 changes mid-route.
    pulse_reset();
    req = 4'b0010; dest = 8'b0000_0100;
    cycle();
    dest = 8'b0000_1100;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("demux_stable", 8'(ds0), 8'h01);
    end
    req = 4'd0;
    repeat (4) cycle();

    // Reset in the middle of a route.
    req = 4'b1111; dest = 8'h1B;
    repeat (3) cycle();
    check("pre_reset_route", 8'(re0), 8'd1);
    pulse_reset();
    check("reset_grant", 8'(g0), 8'd0);
    check("reset_busy", 8'(b0), 8'd0);
    cycle();
    check("post_reset_grant", 8'(g0), 8'h01);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if ($urandom_range(0, 1) == 0) dest = 8'($urandom);
      data_in = 16'($urandom);
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
